mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning the fixed number of cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..7.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port if_rd, input, 1, instruction-fetch read request, held high until if_done.
REQ-005 SHALL have port if_addr, input, 16, fetch byte address.
REQ-006 SHALL have ports dm_rd and dm_wr, input, 1 each, data read and write requests, held high until dm_done.
REQ-007 SHALL have ports dm_addr and dm_wdata, input, 16 each, data address and write data.
REQ-008 SHALL have ports if_rdata and dm_rdata, output, 16 each, registered read data.
REQ-009 SHALL have ports if_done and dm_done, output, 1 each, one-cycle completion pulses.
REQ-010 SHALL have ports if_stall and dm_stall, output, 1 each, requester must hold its pipeline.
REQ-011 SHALL have ports mem_en, mem_wr, output, 1 each, and mem_addr, mem_wdata, output, 16 each, driving the single-ported unified memory.
REQ-012 SHALL have port mem_rdata, input, 16, memory read data.
REQ-013 SHALL have port err, output, 1, sticky protocol error flag to the clock/reset block.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-015 SHALL, in IDLE with any valid request, latch winner's address/data/direction and move to ISSUE at the next edge; otherwise stay in IDLE.
REQ-016 SHALL assert mem_en for exactly one cycle in ISSUE, with mem_wr, mem_addr, mem_wdata registered from the latched request; all mem_* outputs SHALL be 0 outside ISSUE.
REQ-017 SHALL load a 3-bit counter with MEM_LAT-1 on entering WAIT, decrement each cycle, and, in the cycle it reads 0, capture mem_rdata and move to DONE.
REQ-018 SHALL pulse the granted port's done for the single DONE cycle, with its rdata valid from that cycle until the next capture for that port; write requests return done with rdata unchanged.
REQ-019 SHALL produce request-to-done latency of MEM_LAT+2 cycles counted from the IDLE sampling cycle (4 cycles at default).
REQ-020 SHALL ignore all requests in ISSUE, WAIT and DONE; DONE always returns to IDLE, so a request still high after done is treated as new.
REQ-021 SHALL drive if_stall = if_rd & ~if_done and dm_stall = (dm_rd|dm_wr) & ~dm_done, combinationally.
REQ-022 SHALL, when if_rd and a data request are both pending in IDLE, grant the data port (fixed priority), unless REQ-031 applies.
REQ-023 SHALL set err and grant nothing if dm_rd and dm_wr are both high in IDLE, or the granted address has bit 0 set; err holds until reset.
REQ-024 SHALL treat err as non-blocking for the other port: a valid if_rd concurrent with a faulty data request is granted.

Reset
REQ-025 SHALL, on rst high, asynchronously force state IDLE, counter 0, all outputs 0, err 0, rdata registers 0x0000.
REQ-026 SHALL abandon an in-flight access on reset; no done pulse is ever issued for it and late mem_rdata is discarded.
REQ-027 SHALL begin sampling requests on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL support macro MEM_ARB_RR_EN.
REQ-029 SHALL, with MEM_ARB_RR_EN undefined, use fixed data-first priority per REQ-022.
REQ-030 SHALL, with MEM_ARB_RR_EN defined, keep a last_grant register (reset value = fetch) updated on every grant.
REQ-031 SHALL, with MEM_ARB_RR_EN defined, on a tie grant the port not in last_grant; single requests are granted regardless of last_grant.

Verification
REQ-032 SHALL cover: if_rd=1, if_addr=0x0010, MEM_LAT=2, mem_rdata=0xBEEF at valid cycle -> if_done cycle 4, if_rdata=0xBEEF, if_stall high cycles 0-3.
REQ-033 SHALL cover: dm_wr=1, dm_addr=0x0100, dm_wdata=0x1234 -> single mem_en cycle with mem_wr=1, mem_addr=0x0100, mem_wdata=0x1234; dm_done cycle 4.
REQ-034 SHALL cover: if_rd and dm_rd both held high for 3 transactions -> without macro order DM,DM,DM; with MEM_ARB_RR_EN order DM,IF,DM.
REQ-035 SHALL cover: dm_rd=dm_wr=1 -> err=1 next cycle, no mem_en, err remains 1 for 20 cycles until rst.
REQ-036 SHALL cover: rst asserted during WAIT -> all outputs 0 immediately, no done pulse afterwards, next request completes with normal 4-cycle latency.
REQ-037 SHALL cover: MEM_LAT=1 and MEM_LAT=7 -> done at cycles 3 and 9 respectively.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter for a single-ported unified memory with fixed read latency MEM_LAT.
// Define MEM_ARB_RR_EN to replace fixed data-first priority with round-robin on ties.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rd,
    input  logic [15:0] if_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] if_rdata,
    output logic [15:0] dm_rdata,
    output logic        if_done,
    output logic        dm_done,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        sel_dm_q;
    logic        wr_q;
    logic        err_q;
    logic        if_done_q, dm_done_q;
    logic [15:0] if_rdata_q, dm_rdata_q;
    logic        mem_en_q, mem_wr_q;
    logic [15:0] mem_addr_q, mem_wdata_q;
`ifdef MEM_ARB_RR_EN
    logic        last_dm_q;
`endif

    logic dm_req, dm_fault, if_fault, dm_ok, if_ok;
    logic grant_dm_d, grant_if_d;

    // A faulty request only poisons its own port; the other port may still win.
    always_comb begin
        dm_req   = dm_rd | dm_wr;
        dm_fault = (dm_rd & dm_wr) | (dm_req & dm_addr[0]);
        if_fault = if_rd & if_addr[0];
        dm_ok    = dm_req & ~dm_fault;
        if_ok    = if_rd & ~if_fault;
`ifdef MEM_ARB_RR_EN
        grant_dm_d = dm_ok & (~if_ok | ~last_dm_q);
`else
        grant_dm_d = dm_ok;
`endif
        grant_if_d = if_ok & ~grant_dm_d;
    end

    // NOTE: every register here uses <= so all updates see pre-edge values; the
    // memory outputs and done pulses default to 0 and are set only where they apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_dm_q    <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (dm_fault | if_fault) err_q <= 1'b1;
                    if (grant_dm_d | grant_if_d) begin
                        state_q     <= ISSUE;
                        sel_dm_q    <= grant_dm_d;
                        wr_q        <= grant_dm_d & dm_wr;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= grant_dm_d & dm_wr;
                        mem_addr_q  <= grant_dm_d ? dm_addr : if_addr;
                        mem_wdata_q <= (grant_dm_d & dm_wr) ? dm_wdata : '0;
`ifdef MEM_ARB_RR_EN
                        last_dm_q   <= grant_dm_d;
`endif
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= 3'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                        if (sel_dm_q) begin
                            dm_done_q <= 1'b1;
                            if (!wr_q) dm_rdata_q <= mem_rdata;
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_rd & ~if_done_q;
    assign dm_stall  = (dm_rd | dm_wr) & ~dm_done_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance at MEM_LAT=2 plus MEM_LAT=1/7 instances on shared requests.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        if_rd, dm_rd, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata;

    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, dm_done, if_stall, dm_stall, mem_en, mem_wr, err;

    logic [15:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_done, l1_dm_done, l1_if_stall, l1_dm_stall, l1_mem_en, l1_mem_wr, l1_err;
    logic [15:0] l7_if_rdata, l7_dm_rdata, l7_mem_addr, l7_mem_wdata, l7_mem_rdata;
    logic        l7_if_done, l7_dm_done, l7_if_stall, l7_dm_stall, l7_mem_en, l7_mem_wr, l7_err;

    mem_arbiter #(.MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .if_rd(if_rd), .if_addr(if_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .if_rdata(if_rdata), .dm_rdata(dm_rdata),
        .if_done(if_done), .dm_done(dm_done), .if_stall(if_stall), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err));

    mem_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .if_rd(if_rd), .if_addr(if_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .if_rdata(l1_if_rdata), .dm_rdata(l1_dm_rdata),
        .if_done(l1_if_done), .dm_done(l1_dm_done), .if_stall(l1_if_stall), .dm_stall(l1_dm_stall),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .err(l1_err));

    mem_arbiter #(.MEM_LAT(7)) u_lat7 (
        .clk(clk), .rst(rst), .if_rd(if_rd), .if_addr(if_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .if_rdata(l7_if_rdata), .dm_rdata(l7_dm_rdata),
        .if_done(l7_if_done), .dm_done(l7_dm_done), .if_stall(l7_if_stall), .dm_stall(l7_dm_stall),
        .mem_en(l7_mem_en), .mem_wr(l7_mem_wr), .mem_addr(l7_mem_addr), .mem_wdata(l7_mem_wdata),
        .mem_rdata(l7_mem_rdata), .err(l7_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data is valid only in the cycle exactly MEM_LAT after mem_en, 0xDEAD otherwise.
    logic [15:0] mem [256];
    bit          written [256];
    bit   [1:0]  m_v;
    bit   [15:0] m_d [2];
    bit          l1_v;
    bit   [15:0] l1_d;
    bit   [6:0]  l7_v;
    bit   [15:0] l7_d [7];

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (written[a[8:1]])  return mem[a[8:1]];
        if (a == 16'h0010)    return 16'hBEEF;
        if (a == 16'h0020)    return 16'h7777;
        return ~a;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            mem[mem_addr[8:1]]     <= mem_wdata;
            written[mem_addr[8:1]] <= 1'b1;
        end
        m_v  <= {m_v[0], mem_en && !mem_wr};
        m_d[1] <= m_d[0];
        m_d[0] <= mem_read(mem_addr);
        l1_v <= l1_mem_en && !l1_mem_wr;
        l1_d <= l1_mem_addr ^ 16'h5A5A;
        l7_v <= {l7_v[5:0], l7_mem_en && !l7_mem_wr};
        for (int i = 6; i > 0; i--) l7_d[i] <= l7_d[i-1];
        l7_d[0] <= l7_mem_addr ^ 16'h5A5A;
    end

    assign mem_rdata    = m_v[1]  ? m_d[1]  : 16'hDEAD;
    assign l1_mem_rdata = l1_v    ? l1_d    : 16'hDEAD;
    assign l7_mem_rdata = l7_v[6] ? l7_d[6] : 16'hDEAD;

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          if_cyc, dm_cyc, l1_cyc, l7_cyc, en_cnt;
    logic        cap_wr;
    logic [15:0] cap_addr, cap_wdata, l1_rd, l7_rd;
    logic [11:0] if_stall_hist, dm_stall_hist;

    task automatic reset_dut();
        if_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Observes 12 cycles from the IDLE sampling cycle (cycle 0); drops each request after its done.
    task automatic run_txn();
        if_cyc = -1; dm_cyc = -1; l1_cyc = -1; l7_cyc = -1; en_cnt = 0;
        cap_wr = 1'b0; cap_addr = '0; cap_wdata = '0; l1_rd = '0; l7_rd = '0;
        if_stall_hist = '0; dm_stall_hist = '0;
        for (int k = 0; k < 12; k++) begin
            logic drop_if, drop_dm;
            @(negedge clk);
            if (mem_en) begin
                en_cnt++; cap_wr = mem_wr; cap_addr = mem_addr; cap_wdata = mem_wdata;
            end
            if_stall_hist[k] = if_stall;
            dm_stall_hist[k] = dm_stall;
            if (if_done && if_cyc < 0) if_cyc = k;
            if (dm_done && dm_cyc < 0) dm_cyc = k;
            if (l1_if_done && l1_cyc < 0) begin l1_cyc = k; l1_rd = l1_if_rdata; end
            if (l7_if_done && l7_cyc < 0) begin l7_cyc = k; l7_rd = l7_if_rdata; end
            drop_if = if_done;
            drop_dm = dm_done;
            @(posedge clk);
            #1;
            if (drop_if) if_rd = 1'b0;
            if (drop_dm) begin dm_rd = 1'b0; dm_wr = 1'b0; end
        end
        if_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    endtask

    initial begin
        int       n_done, err_hi;
        logic [5:0] order;
        rst = 1'b1;
        if_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        #3;
        check("reset_outputs", {if_done, dm_done, if_stall, dm_stall, mem_en, mem_wr, err}, 32'd0);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        check("reset_rdata", {if_rdata, dm_rdata}, 32'd0);
        reset_dut();

        // Fetch read: done in cycle 4, stall high in cycles 0-3.
        if_rd = 1'b1; if_addr = 16'h0010;
        run_txn();
        check("if_latency", if_cyc, 4);
        check("if_rdata", if_rdata, 16'hBEEF);
        check("if_stall_hist", if_stall_hist, 12'h00F);
        check("if_mem_en_cnt", en_cnt, 1);
        check("if_mem_addr", {cap_wr, cap_addr}, {1'b0, 16'h0010});

        // Reset in WAIT of a second fetch: outputs clear at once, no late done.
        if_rd = 1'b1; if_addr = 16'h0020;
        repeat (2) begin @(posedge clk); #1; end
        if_rd = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_wait_rdata", if_rdata, 16'h0000);
        check("rst_wait_ctrl", {if_done, dm_done, mem_en, mem_wr, err, if_stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (if_done || dm_done) n_done++;
        end
        check("rst_no_done", n_done, 0);
        @(posedge clk); #1;
        if_rd = 1'b1; if_addr = 16'h0010;
        run_txn();
        check("rst_next_latency", if_cyc, 4);
        check("rst_next_rdata", if_rdata, 16'hBEEF);

        // Data write then read-back, then a second write that must not touch dm_rdata.
        reset_dut();
        dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
        run_txn();
        check("wr_latency", dm_cyc, 4);
        check("wr_mem_en_cnt", en_cnt, 1);
        check("wr_mem_bus", {cap_wr, cap_addr, cap_wdata}, {1'b1, 16'h0100, 16'h1234});
        check("wr_dm_rdata", dm_rdata, 16'h0000);
        check("wr_dm_stall_hist", dm_stall_hist, 12'h00F);
        dm_rd = 1'b1; dm_addr = 16'h0100;
        run_txn();
        check("rd_latency", dm_cyc, 4);
        check("rd_dm_rdata", dm_rdata, 16'h1234);
        check("rd_mem_wr", cap_wr, 1'b0);
        dm_wr = 1'b1; dm_addr = 16'h0102; dm_wdata = 16'h5555;
        run_txn();
        check("wr2_latency", dm_cyc, 4);
        check("wr2_dm_rdata_kept", dm_rdata, 16'h1234);

        // Both ports held for three transactions.
        reset_dut();
        if_rd = 1'b1; if_addr = 16'h0010; dm_rd = 1'b1; dm_addr = 16'h0100;
        n_done = 0; order = '0;
        for (int k = 0; k < 40 && n_done < 3; k++) begin
            @(negedge clk);
            if (dm_done) begin order = {order[3:0], 2'd1}; n_done++; end
            if (if_done) begin order = {order[3:0], 2'd2}; n_done++; end
            @(posedge clk); #1;
        end
        if_rd = 1'b0; dm_rd = 1'b0;
        check("tie_count", n_done, 3);
`ifdef MEM_ARB_RR_EN
        check("tie_order", order, 6'b01_10_01);
`else
        check("tie_order", order, 6'b01_01_01);
`endif

        // Simultaneous read and write: sticky err, no memory access.
        reset_dut();
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100;
        @(negedge clk);
        check("err_cycle0", err, 1'b0);
        en_cnt = 0; err_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (err) err_hi++;
        end
        check("err_no_mem_en", en_cnt, 0);
        check("err_sticky", err_hi, 20);
        check("err_no_done", dm_done, 1'b0);
        reset_dut();
        #1;
        check("err_cleared", err, 1'b0);

        // Misaligned fetch address: err, nothing granted.
        if_rd = 1'b1; if_addr = 16'h0011;
        run_txn();
        check("misalign_no_mem_en", en_cnt, 0);
        check("misalign_no_done", if_cyc, -1);
        check("misalign_err", err, 1'b1);

        // Faulty data request alongside a valid fetch: fetch still served.
        reset_dut();
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100;
        if_rd = 1'b1; if_addr = 16'h0010;
        run_txn();
        check("nonblock_if_latency", if_cyc, 4);
        check("nonblock_if_rdata", if_rdata, 16'hBEEF);
        check("nonblock_no_dm_done", dm_cyc, -1);
        check("nonblock_err", err, 1'b1);

        // Latency extremes on the side instances.
        reset_dut();
        if_rd = 1'b1; if_addr = 16'h0010;
        run_txn();
        check("lat1_latency", l1_cyc, 3);
        check("lat1_rdata", l1_rd, 16'h5A4A);
        check("lat7_latency", l7_cyc, 9);
        check("lat7_rdata", l7_rd, 16'h5A4A);
        check("lat2_latency", if_cyc, 4);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
